seg7_scan_scheduler: RTL
========================

// Module: seg7_scan_scheduler
// PURPOSE
//  Time-multiplexes one shared 7-segment cathode bus among 4 digit requesters.
//  Owns the scan timebase: per-digit dwell counter, anti-ghost blanking gap,
//  round-robin skip of masked digits, hex decode. Sits between the counter/
//  control datapath and the board anodes/cathodes.
//  Replaces ad-hoc scan-select taps off free-running dividers.
// PARAMETERS
//  SCAN_DIV   65536  clk cycles a digit is shown per visit (>=16)
//  BLANK_CYC  256    clk cycles all anodes off between digits (>=1)
//  CNT_W      17     dwell/blank counter width; must hold max(SCAN_DIV,BLANK_CYC)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  digit_val  in   16  4 nibbles; [3:0]=digit0 ... [15:12]=digit3
//  digit_dp   in   4   decimal point request per digit, 1=lit
//  digit_en   in   4   per-digit enable mask, 1=scan this digit
//  seg_n      out  8   cathodes, active-low; [6:0]=gfedcba, [7]=dp
//  an_n       out  4   anodes, active-low, one-hot-low or all 1
//  scan_sel   out  2   index of digit being shown/next shown
//  frame_tick out  1   1-cycle pulse when the BLANK that precedes a wrap to a lower index ends
// BEHAVIOUR
//  Reset (async, immediate): state=BLANK, scan_sel=3, cnt=0, an_n=4'hF,
//   seg_n=8'hFF, frame_tick=0. All outputs registered.
//  States: IDLE, SHOW, BLANK.
//  BLANK: an_n=4'hF, seg_n=8'hFF; cnt counts 0..BLANK_CYC-1. At terminal count:
//   if digit_en==0 -> IDLE; else scan_sel <= first enabled index after current
//   (circular, 3 wraps to 0), latch that digit's nibble+dp, cnt<=0, -> SHOW.
//  SHOW: an_n[scan_sel]=0, others 1; seg_n = decode(latched nibble), dp bit.
//   Counts 0..SCAN_DIV-1, then -> BLANK, cnt<=0.
//  Latching: nibble/dp sampled only on BLANK->SHOW edge; input changes mid-SHOW
//   not visible until the digit's next visit (no tearing).
//  Mask change mid-SHOW clearing current digit's enable: next cycle -> BLANK,
//   cnt<=0 (dwell aborted). Mask change in BLANK takes effect at its end.
//  Single enabled digit: re-shows itself; BLANK gap still inserted.
//  IDLE: outputs blank; when digit_en!=0 -> BLANK (cnt<=0), normal selection.
//  frame_tick: asserted the cycle BLANK->SHOW selects an index <= prior index.
//  Decode: 0-9 standard, A b C d E F; active-low, e.g. 1 -> 7'h79, 8 -> 7'h00.
//  Latency: an_n/seg_n change 1 clk after the state change decision.
// CONFIGURATION
//  BRIGHT_PWM_EN defined: adds input bright [3:0]. In SHOW, an_n[scan_sel] low
//   only when cnt[3:0] < bright; else 4'hF. bright=0 -> dark, 15 -> 15/16 duty.
//   seg_n unaffected by PWM. State timing identical to non-PWM build.
//  Not defined: no bright port; anode low for entire SHOW.
// STRUCTURE
//  Package seg7_pkg: state encoding (IDLE/SHOW/BLANK), SEG_BLANK=8'hFF,
//   AN_OFF=4'hF, 16-entry hex->gfedcba active-low table.
//  Sub-module seg7_hex_decoder: combinational nibble -> 7 segment bits.
//  Top holds FSM, counter, round-robin next-index logic, output registers.
// TESTING  (bench: SCAN_DIV=8, BLANK_CYC=2)
//  Reset held 3 clk -> an_n=F, seg_n=FF; release -> 2 blank clk, then an_n=1110.
//  digit_val=16'h4321, dp=0, en=F -> an_n 1110,1101,1011,0111 each 8 clk, 2-clk
//   blank between; seg_n F9,A4,B0,99; frame_tick once per 40 clk.
//  en=4'b0101 -> only 1110/1011 alternate; 3->0 wrap skips digits 1,3.
//  Clear en[scan_sel] at SHOW cnt=3 -> next clk an_n=F, BLANK 2 clk, next digit.
//  en=0 -> IDLE, outputs blank indefinitely; en=4'b1000 -> 2 blank clk, an_n=0111.
//  Change digit_val mid-SHOW -> seg_n unchanged until that digit's next visit;
//   assert reset mid-SHOW -> same cycle an_n=F, seg_n=FF.
//  BRIGHT_PWM_EN, SCAN_DIV=32, bright=4 -> anode low 4 of each 16 SHOW clk.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan scheduler: FSM encoding, blank
// patterns and the active-low hex -> gfedcba segment table.
package seg7_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Bit order gfedcba, 0 = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble -> active-low gfedcba segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scans four digits over one shared cathode bus with a blanking gap between
// visits. Optional anode PWM dimming is enabled by defining BRIGHT_PWM_EN.
module seg7_scan_scheduler
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 65536,
  parameter int BLANK_CYC = 256,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digit_val,
  input  logic [3:0]  digit_dp,
  input  logic [3:0]  digit_en,
`ifdef BRIGHT_PWM_EN
  input  logic [3:0]  bright,
`endif
  output logic [7:0]  seg_n,
  output logic [3:0]  an_n,
  output logic [1:0]  scan_sel,
  output logic        frame_tick,
  output logic [1:0]  fsm_state
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       sel_nx, next_idx, cand;
  logic             found, take;
  logic [3:0]       nib_q, nib_nx;
  logic             dp_q, dp_nx;
  logic [6:0]       seg_dec;
  logic             an_on;

  assign fsm_state = state;

  // First enabled digit strictly after the current one, wrapping; a lone
  // enabled digit finds itself at offset 4.
  always_comb begin
    next_idx = scan_sel;
    found    = 1'b0;
    cand     = scan_sel;
    for (int k = 1; k <= 4; k++) begin
      cand = scan_sel + 2'(k);
      if (!found && digit_en[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    sel_nx   = scan_sel;
    take     = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nx = '0;
          if (digit_en == 4'h0) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_SHOW;
            sel_nx   = next_idx;
            take     = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        // Losing our own enable aborts the dwell immediately.
        if (!digit_en[scan_sel] || cnt == SHOW_LAST) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end
      end
      default: begin
        cnt_nx = '0;
        if (digit_en != 4'h0) state_nx = ST_BLANK;
      end
    endcase
  end

  // Digit data is captured only when a visit starts, so a visit never tears.
  assign nib_nx = take ? digit_val[{sel_nx, 2'b00} +: 4] : nib_q;
  assign dp_nx  = take ? digit_dp[sel_nx] : dp_q;

  seg7_hex_decoder u_dec (
    .nibble (nib_nx),
    .seg    (seg_dec)
  );

`ifdef BRIGHT_PWM_EN
  assign an_on = (cnt_nx[3:0] < bright);
`else
  assign an_on = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      scan_sel   <= 2'd3;
      nib_q      <= 4'h0;
      dp_q       <= 1'b0;
      an_n       <= AN_OFF;
      seg_n      <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      scan_sel   <= sel_nx;
      nib_q      <= nib_nx;
      dp_q       <= dp_nx;
      an_n       <= (state_nx == ST_SHOW && an_on) ? ~(4'b0001 << sel_nx) : AN_OFF;
      seg_n      <= (state_nx == ST_SHOW) ? {~dp_nx, seg_dec} : SEG_BLANK;
      frame_tick <= take && (sel_nx <= scan_sel);
    end
  end

endmodule
